// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings and lane/alignment helpers shared by the SRAM controller.
// The misalignment helper is only consumed when AHB_SRAM_ERR_EN is defined.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_IDLE,
        ERR_CYC1,
        ERR_CYC2
    } err_state_t;

    // Sizes above a word fall through to full-word lanes, which also aligns down.
    function automatic logic [3:0] lane_ben(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: lane_ben = 4'b0001 << addr;
            HSIZE_HALF: lane_ben = addr[1] ? 4'b1100 : 4'b0011;
            default:    lane_ben = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr);
        is_misaligned = (size > HSIZE_WORD) ||
                        ((size == HSIZE_HALF) && addr[0]) ||
                        ((size == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// One-entry posted-write buffer with read forwarding; the forward mask is
// computed against the buffer contents as they will be after the current edge.
module ahb_sram_wbuf
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_capture,
    input  logic [ADDR_W-1:0] i_cap_addr,
    input  logic [3:0]        i_cap_ben,
    input  logic [31:0]       i_cap_data,
    input  logic              i_drain,
    input  logic              i_rd_acc,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [3:0]        o_ben,
    output logic [31:0]       o_data,
    output logic [3:0]        o_fwd_mask,
    output logic [31:0]       o_fwd_data
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_ben;
    logic [31:0]       r_data;
    logic [3:0]        r_fwd_mask;
    logic [31:0]       r_fwd_data;

    logic              w_valid_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [3:0]        w_ben_next;
    logic [31:0]       w_data_next;

    assign w_valid_next = i_capture | (r_valid & ~i_drain);
    assign w_addr_next  = i_capture ? i_cap_addr : r_addr;
    assign w_ben_next   = i_capture ? i_cap_ben  : r_ben;
    assign w_data_next  = i_capture ? i_cap_data : r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_ben      <= 4'b0000;
            r_data     <= '0;
            r_fwd_mask <= 4'b0000;
            r_fwd_data <= '0;
        end else begin
            r_valid <= w_valid_next;
            if (i_capture) begin
                r_addr <= i_cap_addr;
                r_ben  <= i_cap_ben;
                r_data <= i_cap_data;
            end
            if (i_rd_acc) begin
                r_fwd_mask <= (w_valid_next && (w_addr_next == i_rd_addr)) ? w_ben_next : 4'b0000;
                r_fwd_data <= w_data_next;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_addr     = r_addr;
    assign o_ben      = r_ben;
    assign o_data     = r_data;
    assign o_fwd_mask = r_fwd_mask;
    assign o_fwd_data = r_fwd_data;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait AHB-Lite slave in front of a single-port 32-bit SRAM.
// Define AHB_SRAM_ERR_EN to answer misaligned/oversized transfers with ERROR.
module ahb_sram_ctrl
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_ben,
    output logic              ram_wren,
    input  logic [31:0]       ram_dout
);

    logic              w_acc;
    logic              w_err;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W-1:0] w_haddr_word;
    logic              w_capture;
    logic              w_drain;
    logic              w_buf_valid;
    logic [ADDR_W-1:0] w_buf_addr;
    logic [3:0]        w_buf_ben;
    logic [31:0]       w_buf_data;
    logic [3:0]        w_fwd_mask;
    logic [31:0]       w_fwd_data;
    logic [31:0]       w_rd_merged;
    logic              w_unused;

    logic              r_rd_dp;
    logic              r_wr_dp;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [3:0]        r_wr_ben;
    logic [31:0]       r_hrdata;

    assign w_acc        = hsel & htrans[1] & hready;
    assign w_haddr_word = haddr[ADDR_W+1:2];
    assign w_unused     = ^{haddr[31:ADDR_W+2], htrans[0]};

`ifdef AHB_SRAM_ERR_EN
    err_state_t r_err_state;
    logic       r_hreadyout;
    logic       r_hresp;

    assign w_err = w_acc & is_misaligned(hsize, haddr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_state <= ERR_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_err_state)
                ERR_CYC1: begin
                    r_err_state <= ERR_CYC2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    // The second error cycle has hready high, so a new transfer may start there.
                    if (w_err) begin
                        r_err_state <= ERR_CYC1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end else begin
                        r_err_state <= ERR_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
`else
    assign w_err     = 1'b0;
    assign hreadyout = 1'b1;
    assign hresp     = HRESP_OKAY;
`endif

    assign w_rd_acc = w_acc & ~w_err & ~hwrite;
    assign w_wr_acc = w_acc & ~w_err & hwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_dp   <= 1'b0;
            r_wr_dp   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_ben  <= 4'b0000;
            r_hrdata  <= '0;
        end else begin
            r_rd_dp <= w_rd_acc;
            r_wr_dp <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr <= w_haddr_word;
                r_wr_ben  <= lane_ben(hsize, haddr[1:0]);
            end
            if (r_rd_dp)
                r_hrdata <= w_rd_merged;
        end
    end

    // Reads own the port; a pending drain or data-phase write yields to them.
    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_ben  = 4'b0000;
        ram_wren = 1'b0;
        if (w_rd_acc) begin
            ram_addr = w_haddr_word;
            ram_ben  = 4'b1111;
        end else if (w_buf_valid) begin
            ram_addr = w_buf_addr;
            ram_din  = w_buf_data;
            ram_ben  = w_buf_ben;
            ram_wren = 1'b1;
        end else if (r_wr_dp) begin
            ram_addr = r_wr_addr;
            ram_din  = hwdata;
            ram_ben  = r_wr_ben;
            ram_wren = 1'b1;
        end
    end

    assign w_capture = r_wr_dp & (w_rd_acc | w_buf_valid);
    assign w_drain   = w_buf_valid & ~w_rd_acc;

    ahb_sram_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_capture  (w_capture),
        .i_cap_addr (r_wr_addr),
        .i_cap_ben  (r_wr_ben),
        .i_cap_data (hwdata),
        .i_drain    (w_drain),
        .i_rd_acc   (w_rd_acc),
        .i_rd_addr  (w_haddr_word),
        .o_valid    (w_buf_valid),
        .o_addr     (w_buf_addr),
        .o_ben      (w_buf_ben),
        .o_data     (w_buf_data),
        .o_fwd_mask (w_fwd_mask),
        .o_fwd_data (w_fwd_data)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_lane
        assign w_rd_merged[gi*8 +: 8] = w_fwd_mask[gi] ? w_fwd_data[gi*8 +: 8] : ram_dout[gi*8 +: 8];
    end

    assign hrdata = r_rd_dp ? w_rd_merged : r_hrdata;

    a_single_entry: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_wr_dp && w_buf_valid && w_rd_acc));

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl with a behavioural single-port SRAM;
// build with AHB_SRAM_ERR_EN defined to exercise the ERROR response path.
module tb_ahb_sram_ctrl;
    import ahb_lite_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [31:0]       hrdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [3:0]        ram_ben;
    logic              ram_wren;
    logic [31:0]       ram_dout;

    int total = 0;
    int bad = 0;
    int wren_cnt = 0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    ahb_sram_ctrl #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hready    (hreadyout),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_ben   (ram_ben),
        .ram_wren  (ram_wren),
        .ram_dout  (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_wren === 1'b1) begin
            for (int b = 0; b < 4; b++)
                if (ram_ben[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            wren_cnt <= wren_cnt + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    // One bus cycle: drive address phase plus data-phase hwdata, then park at the falling edge.
    task automatic bus(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                       input logic [2:0] sz, input logic [31:0] wd);
        @(posedge clk);
        #1;
        hsel = 1'b1; htrans = tr; hwrite = wr; haddr = addr; hsize = sz; hwdata = wd;
        @(negedge clk);
        $display("txn t=%0t tr=%0d wr=%0d addr=%h size=%0d wdata=%h | rdata=%h rdy=%0d resp=%0d ram: a=%h we=%0d ben=%b din=%h",
                 $time, tr, wr, addr, sz, wd, hrdata, hreadyout, hresp, ram_addr, ram_wren, ram_ben, ram_din);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        haddr = '0; hsize = HSIZE_WORD; hwdata = '0;
        repeat (3) @(negedge clk);
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout: got %b want 1", hreadyout); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp: got %b want 0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata: got %h want 0", hrdata); end
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        total++; if (ram_ben !== 4'b0000) begin bad++; $display("FAIL rst_ben: got %b want 0000", ram_ben); end
        total++; if (ram_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus((i % 2 == 0) ? HTRANS_IDLE : HTRANS_BUSY, i[0], 32'h10 * i, HSIZE_WORD, 32'hFFFF_FFFF);
            total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL idle_wren[%0d]: got %b want 0", i, ram_wren); end
            total++; if (hresp !== 1'b0) begin bad++; $display("FAIL idle_hresp[%0d]: got %b want 0", i, hresp); end
        end
        total++; if (wren_cnt !== 0) begin bad++; $display("FAIL idle_wren_count: got %0d want 0", wren_cnt); end
    endtask

    task automatic test_word_rw();
        bus(HTRANS_NONSEQ, 1'b1, 32'h000, HSIZE_WORD, 32'h0);
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL wr_addr_phase_wren: got %b want 0", ram_wren); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'hDEAD_BEEF);
        total++; if ({ram_wren, ram_ben, ram_addr, ram_din} !== {1'b1, 4'b1111, 10'd0, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL word_write_port: got we=%b ben=%b a=%h d=%h want we=1 ben=1111 a=000 d=deadbeef",
                            ram_wren, ram_ben, ram_addr, ram_din); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        bus(HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
        total++; if ({ram_wren, ram_ben, ram_addr} !== {1'b0, 4'b1111, 10'd0}) begin
            bad++; $display("FAIL word_read_port: got we=%b ben=%b a=%h want we=0 ben=1111 a=000", ram_wren, ram_ben, ram_addr); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word_read_data: got %h want deadbeef", hrdata); end
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL word_read_ready: got %b want 1", hreadyout); end
    endtask

    task automatic test_forward();
        bus(HTRANS_NONSEQ, 1'b1, 32'h004, HSIZE_WORD, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h1122_3344);
        bus(HTRANS_NONSEQ, 1'b1, 32'h005, HSIZE_BYTE, 32'h0);
        bus(HTRANS_NONSEQ, 1'b0, 32'h004, HSIZE_WORD, 32'h0000_5500);
        total++; if ({ram_wren, ram_ben, ram_addr} !== {1'b0, 4'b1111, 10'd1}) begin
            bad++; $display("FAIL fwd_read_wins: got we=%b ben=%b a=%h want we=0 ben=1111 a=001", ram_wren, ram_ben, ram_addr); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (hrdata !== 32'h1122_5544) begin bad++; $display("FAIL fwd_data: got %h want 11225544", hrdata); end
        total++; if ({ram_wren, ram_ben, ram_addr, ram_din} !== {1'b1, 4'b0010, 10'd1, 32'h0000_5500}) begin
            bad++; $display("FAIL fwd_drain: got we=%b ben=%b a=%h d=%h want we=1 ben=0010 a=001 d=00005500",
                            ram_wren, ram_ben, ram_addr, ram_din); end
        bus(HTRANS_NONSEQ, 1'b0, 32'h004, HSIZE_WORD, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (hrdata !== 32'h1122_5544) begin bad++; $display("FAIL fwd_sram_after: got %h want 11225544", hrdata); end
    endtask

    task automatic test_half_write();
        bus(HTRANS_NONSEQ, 1'b1, 32'h00A, HSIZE_HALF, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'hA5A5_0000);
        total++; if ({ram_wren, ram_ben, ram_addr, ram_din[31:16]} !== {1'b1, 4'b1100, 10'd2, 16'hA5A5}) begin
            bad++; $display("FAIL half_write_port: got we=%b ben=%b a=%h d=%h want we=1 ben=1100 a=002 d[31:16]=a5a5",
                            ram_wren, ram_ben, ram_addr, ram_din); end
    endtask

    task automatic test_back_to_back();
        logic        wr_t  [0:7];
        logic [31:0] ad_t  [0:7];
        logic [31:0] dt_t  [0:7];
        logic [31:0] rb_t  [0:7];
        wr_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ad_t = '{32'h40, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h4C, 32'h50};
        dt_t = '{32'hA000_0000, 32'hA000_0000, 32'hA111_1111, 32'hC0DE_0002,
                 32'hA333_3333, 32'hA444_4444, 32'hA333_3333, 32'hA444_4444};
        rb_t = '{32'hA000_0000, 32'hA111_1111, 32'hC0DE_0002, 32'hA333_3333,
                 32'hA444_4444, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007};
        for (int i = 0; i <= 8; i++)
            bus((i < 8) ? HTRANS_NONSEQ : HTRANS_IDLE, 1'b1, 32'h40 + 4 * i, HSIZE_WORD,
                (i > 0) ? 32'hC0DE_0000 + (i - 1) : 32'h0);
        for (int i = 0; i <= 8; i++) begin
            bus((i < 8) ? HTRANS_NONSEQ : HTRANS_IDLE, (i < 8) ? wr_t[i] : 1'b0, (i < 8) ? ad_t[i] : 32'h0,
                HSIZE_WORD, (i > 0 && wr_t[i-1]) ? dt_t[i-1] : 32'h0);
            total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, hreadyout); end
            if (i > 0 && !wr_t[i-1]) begin
                total++; if (hrdata !== dt_t[i-1]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i - 1, hrdata, dt_t[i-1]); end
            end
        end
        for (int i = 0; i <= 8; i++) begin
            bus((i < 8) ? HTRANS_NONSEQ : HTRANS_IDLE, 1'b0, 32'h40 + 4 * i, HSIZE_WORD, 32'h0);
            if (i > 0) begin
                total++; if (hrdata !== rb_t[i-1]) begin bad++; $display("FAIL b2b_readback[%0d]: got %h want %h", i - 1, hrdata, rb_t[i-1]); end
            end
        end
    endtask

    task automatic test_misaligned();
        int cnt0;
        cnt0 = wren_cnt;
        bus(HTRANS_NONSEQ, 1'b1, 32'h001, HSIZE_HALF, 32'h0);
`ifdef AHB_SRAM_ERR_EN
        total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL err_addr_phase: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0000_1234);
        total++; if ({hreadyout, hresp, ram_wren} !== 3'b010) begin
            bad++; $display("FAIL err_cycle1: got rdy=%b resp=%b we=%b want rdy=0 resp=1 we=0", hreadyout, hresp, ram_wren); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if ({hreadyout, hresp, ram_wren} !== 3'b110) begin
            bad++; $display("FAIL err_cycle2: got rdy=%b resp=%b we=%b want rdy=1 resp=1 we=0", hreadyout, hresp, ram_wren); end
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL err_done: got rdy=%b resp=%b want rdy=1 resp=0", hreadyout, hresp); end
        total++; if (wren_cnt !== cnt0) begin bad++; $display("FAIL err_no_write: got %0d writes want 0", wren_cnt - cnt0); end
        total++; if (hrdata !== 32'hC0DE_0007) begin bad++; $display("FAIL err_hrdata_hold: got %h want c0de0007", hrdata); end
`else
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0000_1234);
        total++; if ({ram_wren, ram_ben, ram_addr, hresp} !== {1'b1, 4'b0011, 10'd0, 1'b0}) begin
            bad++; $display("FAIL mis_half_port: got we=%b ben=%b a=%h resp=%b want we=1 ben=0011 a=000 resp=0",
                            ram_wren, ram_ben, ram_addr, hresp); end
        total++; if (hrdata !== 32'hC0DE_0007) begin bad++; $display("FAIL mis_hrdata_hold: got %h want c0de0007", hrdata); end
        bus(HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (hrdata !== 32'hDEAD_1234) begin bad++; $display("FAIL mis_half_readback: got %h want dead1234", hrdata); end
        total++; if (wren_cnt !== cnt0 + 1) begin bad++; $display("FAIL mis_half_writes: got %0d want 1", wren_cnt - cnt0); end
`endif
    endtask

    task automatic test_reset_mid();
        int cnt0;
        bus(HTRANS_NONSEQ, 1'b1, 32'h060, HSIZE_WORD, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h600D_600D);
        bus(HTRANS_NONSEQ, 1'b1, 32'h060, HSIZE_WORD, 32'h0);
        bus(HTRANS_NONSEQ, 1'b0, 32'h064, HSIZE_WORD, 32'hBAD0_BAD0);
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rmid_read_phase_wren: got %b want 0", ram_wren); end
        @(posedge clk);
        #1;
        rst_n = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = '0;
        cnt0 = wren_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rmid_wren[%0d]: got %b want 0", i, ram_wren); end
        end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rmid_hrdata: got %h want 0", hrdata); end
        @(posedge clk); #1; rst_n = 1'b1;
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rmid_after_wren: got %b want 0", ram_wren); end
        bus(HTRANS_NONSEQ, 1'b0, 32'h060, HSIZE_WORD, 32'h0);
        bus(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        total++; if (hrdata !== 32'h600D_600D) begin bad++; $display("FAIL rmid_lost_write: got %h want 600d600d", hrdata); end
        total++; if (wren_cnt !== cnt0) begin bad++; $display("FAIL rmid_write_count: got %0d want 0", wren_cnt - cnt0); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_forward();
        test_half_write();
        test_back_to_back();
        test_misaligned();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
